// File: rtl/hw7_pkg.sv
// Shared constants and opcode classification for the hw7 execute-stage ALU.
// Exports: WIDTH_DEF, opcode localparams OP_AND..OP_MVN, flag indices FL_N/Z/C/V,
// op_class_e plus the helpers op_class(), is_compare() and is_arith().
package hw7_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned FLAG_W    = 4;

    localparam logic [OP_W-1:0] OP_AND = 4'd0;
    localparam logic [OP_W-1:0] OP_EOR = 4'd1;
    localparam logic [OP_W-1:0] OP_SUB = 4'd2;
    localparam logic [OP_W-1:0] OP_RSB = 4'd3;
    localparam logic [OP_W-1:0] OP_ADD = 4'd4;
    localparam logic [OP_W-1:0] OP_ADC = 4'd5;
    localparam logic [OP_W-1:0] OP_SBC = 4'd6;
    localparam logic [OP_W-1:0] OP_RSC = 4'd7;
    localparam logic [OP_W-1:0] OP_TST = 4'd8;
    localparam logic [OP_W-1:0] OP_TEQ = 4'd9;
    localparam logic [OP_W-1:0] OP_CMP = 4'd10;
    localparam logic [OP_W-1:0] OP_CMN = 4'd11;
    localparam logic [OP_W-1:0] OP_ORR = 4'd12;
    localparam logic [OP_W-1:0] OP_MOV = 4'd13;
    localparam logic [OP_W-1:0] OP_BIC = 4'd14;
    localparam logic [OP_W-1:0] OP_MVN = 4'd15;

    localparam int unsigned FL_N = 3;
    localparam int unsigned FL_Z = 2;
    localparam int unsigned FL_C = 1;
    localparam int unsigned FL_V = 0;

    // LOGIC: writes result, N/Z only. ARITH: writes result, NZCV.
    // TEST (TST/TEQ): no result write, N/Z only. CMP (CMP/CMN): no result write, NZCV.
    typedef enum logic [1:0] {
        CLS_LOGIC = 2'd0,
        CLS_ARITH = 2'd1,
        CLS_TEST  = 2'd2,
        CLS_CMP   = 2'd3
    } op_class_e;

    function automatic op_class_e op_class(input logic [OP_W-1:0] op);
        op_class_e cls;
        case (op)
            OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC: cls = CLS_ARITH;
            OP_TST, OP_TEQ:                                 cls = CLS_TEST;
            OP_CMP, OP_CMN:                                 cls = CLS_CMP;
            default:                                        cls = CLS_LOGIC;
        endcase
        return cls;
    endfunction

    function automatic logic is_compare(input op_class_e cls);
        return (cls == CLS_TEST) || (cls == CLS_CMP);
    endfunction

    function automatic logic is_arith(input op_class_e cls);
        return (cls == CLS_ARITH) || (cls == CLS_CMP);
    endfunction

endpackage

// File: rtl/hw7_alu_if.sv
// Operand/result bundle between the issue logic and the ALU.
// master: drives num1, num2, temp, cm; observes FL, num3.
// slave : the ALU; observes operands/opcode, drives FL, num3.
interface hw7_alu_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic [1:0]       temp;
    logic [3:0]       cm;
    logic [3:0]       FL;
    logic [WIDTH-1:0] num3;

    modport master (
        output num1, num2, temp, cm,
        input  FL, num3
    );

    modport slave (
        input  num1, num2, temp, cm,
        output FL, num3
    );

endinterface

// File: rtl/hw7_addsub.sv
// Combinational WIDTH-bit adder: sum = x + y + cin, with carry-out and signed overflow.
// Ports: x, y (operands as seen by the adder), cin -> sum, cout, ovf.
module hw7_addsub #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH:0] full;

    assign full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    assign sum  = full[WIDTH-1:0];
    assign cout = full[WIDTH];
    // Operand signs agree but the result sign differs.
    assign ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);

endmodule

// File: rtl/hw7_alu.sv
// ARM-style data-processing ALU with registered result (num3) and NZCV flags (FL).
// Ports: clk, rst_n (synchronous, active-low), bus (hw7_alu_if.slave: num1, num2,
// temp[0]=carry-in, temp[1]=set-flags, cm=opcode; outputs FL, num3).
module hw7_alu
    import hw7_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    hw7_alu_if.slave   bus
);

    logic [WIDTH-1:0] num3_q;
    logic [3:0]       fl_q;

    logic             ci;
    logic             set_fl;
    op_class_e        cls;
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             add_ovf;
    logic [WIDTH-1:0] result;
    logic [3:0]       fl_next;
    logic             wr_res;
    logic             wr_fl;

    hw7_addsub #(.WIDTH(WIDTH)) u_addsub (
        .x    (add_x),
        .y    (add_y),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

    // Operand routing into the single adder; subtracts are x + ~y + cin.
    always_comb begin
        // Unknown control bits on temp resolve to 0.
        ci      = (bus.temp[0] === 1'b1);
        set_fl  = (bus.temp[1] === 1'b1);
        cls     = op_class(bus.cm);
        add_x   = bus.num1;
        add_y   = bus.num2;
        add_cin = 1'b0;
        case (bus.cm)
            OP_SUB, OP_CMP: begin
                add_y   = ~bus.num2;
                add_cin = 1'b1;
            end
            OP_RSB: begin
                add_x   = bus.num2;
                add_y   = ~bus.num1;
                add_cin = 1'b1;
            end
            OP_ADC: add_cin = ci;
            OP_SBC: begin
                add_y   = ~bus.num2;
                add_cin = ci;
            end
            OP_RSC: begin
                add_x   = bus.num2;
                add_y   = ~bus.num1;
                add_cin = ci;
            end
            default: ;
        endcase
    end

    // Result select, flag computation and write enables.
    always_comb begin
        result = add_sum;
        case (bus.cm)
            OP_AND, OP_TST: result = bus.num1 & bus.num2;
            OP_EOR, OP_TEQ: result = bus.num1 ^ bus.num2;
            OP_ORR:         result = bus.num1 | bus.num2;
            OP_MOV:         result = bus.num2;
            OP_BIC:         result = bus.num1 & ~bus.num2;
            OP_MVN:         result = ~bus.num2;
            default:        result = add_sum;
        endcase

        fl_next       = fl_q;
        fl_next[FL_N] = result[WIDTH-1];
        fl_next[FL_Z] = (result == '0);
        if (is_arith(cls)) begin
            fl_next[FL_C] = add_cout;
            fl_next[FL_V] = add_ovf;
        end

        wr_res = !is_compare(cls);
        wr_fl  = is_compare(cls) || set_fl;
    end

    // Output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num3_q <= '0;
            fl_q   <= 4'b0000;
        end else begin
            if (wr_res) num3_q <= result;
            if (wr_fl)  fl_q   <= fl_next;
        end
    end

    assign bus.num3 = num3_q;
    assign bus.FL   = fl_q;

endmodule

// File: tb/tb_hw7_alu.sv
// Self-checking bench for hw7_alu: reference model fills a scoreboard queue when an op
// is driven; the following negedge pops and compares against the registered outputs.
module tb_hw7_alu;

    typedef struct {
        logic [31:0] num3;
        logic [3:0]  fl;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb_q[$];
    int   n_checks;
    int   n_fail;

    logic [31:0] m_num3;
    logic [3:0]  m_fl;

    hw7_alu_if #(.WIDTH(32)) bus ();

    hw7_alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: exact-width arithmetic, independent of the adder-based RTL.
    task automatic model_push(input logic [31:0] a, input logic [31:0] b,
                              input logic [1:0] t, input logic [3:0] c);
        logic [31:0] res;
        logic        cf;
        logic        vf;
        logic        arith;
        logic        cmp;
        logic        ci;
        longint      sa;
        longint      sb;
        longint      r;
        logic [32:0] u;
        exp_t        e;
        ci    = (t[0] === 1'b1);
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        arith = 1'b1;
        cmp   = (c >= 4'd8) && (c <= 4'd11);
        res   = '0;
        cf    = 1'b0;
        r     = 0;
        case (c)
            4'd2, 4'd10: begin res = a - b; cf = (a >= b); r = sa - sb; end
            4'd3: begin res = b - a; cf = (b >= a); r = sb - sa; end
            4'd4, 4'd11: begin u = {1'b0, a} + {1'b0, b}; res = u[31:0]; cf = u[32]; r = sa + sb; end
            4'd5: begin
                u = {1'b0, a} + {1'b0, b} + {32'd0, ci};
                res = u[31:0]; cf = u[32]; r = sa + sb + longint'(ci);
            end
            4'd6: begin
                res = a - b - {31'd0, !ci};
                cf = ({1'b0, a} >= ({1'b0, b} + {32'd0, !ci}));
                r = sa - sb - longint'(!ci);
            end
            4'd7: begin
                res = b - a - {31'd0, !ci};
                cf = ({1'b0, b} >= ({1'b0, a} + {32'd0, !ci}));
                r = sb - sa - longint'(!ci);
            end
            default: begin
                arith = 1'b0;
                case (c)
                    4'd0, 4'd8: res = a & b;
                    4'd1, 4'd9: res = a ^ b;
                    4'd12: res = a | b;
                    4'd13: res = b;
                    4'd14: res = a & ~b;
                    default: res = ~b;
                endcase
            end
        endcase
        vf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        if (!cmp) m_num3 = res;
        if (cmp || (t[1] === 1'b1)) begin
            m_fl[3] = res[31];
            m_fl[2] = (res == 32'd0);
            if (arith) begin
                m_fl[1] = cf;
                m_fl[0] = vf;
            end
        end
        e.num3 = m_num3;
        e.fl   = m_fl;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] t, input logic [3:0] c);
        bus.num1 = a;
        bus.num2 = b;
        bus.temp = t;
        bus.cm   = c;
        model_push(a, b, t, c);
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        bus.num1 = $urandom; bus.num2 = $urandom;
        bus.temp = 2'($urandom_range(0, 3)); bus.cm = 4'($urandom_range(0, 15));
        m_num3 = '0; m_fl = '0; sb_q.delete();
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.num3 !== 32'd0 || bus.FL !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset got num3=%h FL=%b exp num3=0 FL=0000", bus.num3, bus.FL);
        end
        rst_n = 1'b1;
        drive(32'h11, 32'h101, 2'b10, 4'd4);
        @(negedge clk);
        e = sb_q.pop_front();
        n_checks++;
        if (bus.num3 !== 32'h112 || bus.FL !== 4'b0000 || e.num3 !== 32'h112) begin
            n_fail++;
            $display("FAIL first_op got num3=%h FL=%b exp num3=00000112 FL=0000", bus.num3, bus.FL);
        end
    endtask

    task automatic test_logical();
        logic [3:0]  ops[3]  = '{4'd0, 4'd1, 4'd12};
        logic [31:0] want[3] = '{32'h1, 32'h110, 32'h111};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(32'h11, 32'h101, 2'b10, ops[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks++;
            if (bus.num3 !== want[i] || bus.FL !== e.fl || bus.FL[3:2] !== 2'b00) begin
                n_fail++;
                $display("FAIL logical cm=%0d got num3=%h FL=%b exp num3=%h FL=%b",
                         ops[i], bus.num3, bus.FL, want[i], e.fl);
            end
        end
    endtask

    task automatic test_arith();
        logic [3:0]  ops[3]  = '{4'd2, 4'd3, 4'd4};
        logic [31:0] want[3] = '{32'hFFFFFF10, 32'hF0, 32'h112};
        logic [3:0]  wfl[3]  = '{4'b1000, 4'b0010, 4'b0000};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(32'h11, 32'h101, 2'b10, ops[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks++;
            if (bus.num3 !== want[i] || bus.FL !== wfl[i] || e.fl !== wfl[i]) begin
                n_fail++;
                $display("FAIL arith cm=%0d got num3=%h FL=%b exp num3=%h FL=%b",
                         ops[i], bus.num3, bus.FL, want[i], wfl[i]);
            end
        end
    endtask

    task automatic test_compare();
        exp_t e;
        drive(32'h11, 32'h101, 2'b00, 4'd10);
        @(negedge clk);
        e = sb_q.pop_front();
        n_checks++;
        if (bus.num3 !== 32'h112 || bus.FL !== 4'b1000 || e.fl !== 4'b1000) begin
            n_fail++;
            $display("FAIL cmp_neg got num3=%h FL=%b exp num3=00000112 FL=1000", bus.num3, bus.FL);
        end
        drive(32'd5, 32'd5, 2'b00, 4'd10);
        @(negedge clk);
        e = sb_q.pop_front();
        n_checks++;
        if (bus.num3 !== 32'h112 || bus.FL !== 4'b0110) begin
            n_fail++;
            $display("FAIL cmp_eq got num3=%h FL=%b exp num3=00000112 FL=0110", bus.num3, bus.FL);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] a[3]    = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0};
        logic [31:0] b[3]    = '{32'h1, 32'h1, 32'h0};
        logic [1:0]  t[3]    = '{2'b10, 2'b10, 2'b11};
        logic [3:0]  c[3]    = '{4'd4, 4'd4, 4'd5};
        logic [31:0] want[3] = '{32'h80000000, 32'h0, 32'h1};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(a[i], b[i], t[i], c[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks++;
            if (bus.num3 !== want[i] || bus.FL !== e.fl) begin
                n_fail++;
                $display("FAIL ovf_carry #%0d got num3=%h FL=%b exp num3=%h FL=%b",
                         i, bus.num3, bus.FL, want[i], e.fl);
            end
        end
    endtask

    task automatic test_sflag_disable();
        logic [3:0] prior;
        exp_t e;
        prior = m_fl;
        drive(32'd7, 32'd7, 2'b00, 4'd2);
        @(negedge clk);
        e = sb_q.pop_front();
        n_checks++;
        if (bus.num3 !== 32'd0 || bus.FL !== prior || e.fl !== prior) begin
            n_fail++;
            $display("FAIL sflag_off got num3=%h FL=%b exp num3=0 FL=%b", bus.num3, bus.FL, prior);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] edge_v[4] = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
        logic [31:0] a;
        logic [31:0] b;
        exp_t e;
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
            drive(a, b, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            @(negedge clk);
            e = sb_q.pop_front();
            n_checks++;
            if (bus.num3 !== e.num3 || bus.FL !== e.fl) begin
                n_fail++;
                $display("FAIL b2b #%0d got num3=%h FL=%b exp num3=%h FL=%b",
                         i, bus.num3, bus.FL, e.num3, e.fl);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        drive(32'h80000000, 32'h80000000, 2'b10, 4'd4);
        @(negedge clk);
        e = sb_q.pop_front();
        n_checks++;
        if (bus.FL !== e.fl || bus.FL !== 4'b0111) begin
            n_fail++;
            $display("FAIL pre_reset got FL=%b exp FL=0111", bus.FL);
        end
        rst_n = 1'b0;
        drive(32'h5, 32'h6, 2'b10, 4'd4);
        m_num3 = '0; m_fl = '0; sb_q.delete();
        @(negedge clk);
        n_checks++;
        if (bus.num3 !== 32'd0 || bus.FL !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset got num3=%h FL=%b exp num3=0 FL=0000", bus.num3, bus.FL);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        test_reset();
        test_logical();
        test_arith();
        test_compare();
        test_overflow();
        test_sflag_disable();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
